io_input_port: RTL and testbench

Memory-mapped input peripheral for the microprocessor: the read-side counterpart of the LED output port. It synchronises and debounces eight slide switches and one push-button, latches button presses, and answers CPU read requests over a four-phase req/ack handshake. It sits between the board pins and the CPU data bus.

---
 rtl/io_pkg.sv | 26 ++
 rtl/io_input_port_if.sv | 12 +
 rtl/debounce_bit.sv | 41 ++++
 rtl/io_input_port.sv | 118 +++++++++++
 tb/tb_io_input_port.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped input port: register map,
// status bit layout and the read-handshake state encoding.
package io_pkg;

    localparam logic IO_ADDR_SW     = 1'b0;
    localparam logic IO_ADDR_STATUS = 1'b1;

    localparam int STAT_BTN  = 0;
    localparam int STAT_PEND = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } rd_state_t;

    // Status register image: {6'b0, pend, btn}.
    function automatic logic [7:0] make_status(input logic pend, input logic btn);
        logic [7:0] word;
        word            = 8'h00;
        word[STAT_BTN]  = btn;
        word[STAT_PEND] = pend;
        return word;
    endfunction

endpackage

// File: rtl/io_input_port_if.sv
// CPU read bus of the input port: four-phase req/ack with a one-bit register address.
interface io_input_port_if;

    logic       rd_req;
    logic       rd_addr;
    logic [7:0] rd_data;
    logic       rd_ack;

    modport master (output rd_req, output rd_addr, input rd_data, input rd_ack);
    modport slave  (input rd_req, input rd_addr, output rd_data, output rd_ack);

endinterface

// File: rtl/debounce_bit.sv
// One raw pin: two-flop synchroniser followed by a stable-count debouncer.
// The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             s;
    logic [CNT_W-1:0] c;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values;
        // blocking here would collapse the two synchroniser stages into one.
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            level <= 1'b0;
            c     <= '0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            if (s == level) begin
                c <= '0;
            end else if (c == LAST) begin
                level <= s;
                c     <= '0;
            end else begin
                c <= c + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped input port: debounced switches and push-button, a sticky
// button-press latch, and a req/ack read FSM serving the CPU.
module io_input_port
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      sw,
    input  logic            btn,
    io_input_port_if.slave  bus
);

    logic [7:0] d_sw;
    logic       d_btn;

    for (genvar i = 0; i < 8; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_sw (
            .clk  (clk),
            .rst  (rst),
            .raw  (sw[i]),
            .level(d_sw[i])
        );
    end

    debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn),
        .level(d_btn)
    );

    rd_state_t  state;
    logic       d_btn_q;
    logic       pend;
    logic [7:0] rd_data_q;
    logic       rd_ack_q;

    logic       btn_rise;
    logic       capture;
    logic       status_cap;
    logic [7:0] read_word;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        btn_rise   = 1'b0;
        capture    = 1'b0;
        status_cap = 1'b0;
        read_word  = d_sw;

        btn_rise   = d_btn & ~d_btn_q;
        capture    = (state == IDLE) && bus.rd_req;
        status_cap = capture && (bus.rd_addr == IO_ADDR_STATUS);
        if (bus.rd_addr == IO_ADDR_STATUS) begin
            read_word = make_status(pend, d_btn);
        end
    end

    // A press arriving in the same cycle as a status capture survives the clear;
    // the captured word still carries the old pend.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_btn_q <= 1'b0;
            pend    <= 1'b0;
        end else begin
            d_btn_q <= d_btn;
            if (btn_rise) begin
                pend <= 1'b1;
            end else if (status_cap) begin
                pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_data_q <= 8'h00;
            rd_ack_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        rd_data_q <= read_word;
                        rd_ack_q  <= 1'b1;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    rd_ack_q <= 1'b0;
                    state    <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // The CPU must drop rd_req before another capture can happen.
                    if (!bus.rd_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    rd_ack_q <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_ack  = rd_ack_q;

endmodule

// File: tb/tb_io_input_port.sv
// Self-checking bench for io_input_port with DEBOUNCE_CYCLES=4: vector table for
// register reads, scoreboard for returned data, hand sequences for the corner cases.
module tb_io_input_port;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic       btn;

    io_input_port_if bus ();

    io_input_port #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw (sw),
        .btn(btn),
        .bus(bus)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [7:0] sw;
        logic       btn;
        logic       addr;
        logic [7:0] exp;
    } vec_t;

    int         compared   = 0;
    int         mismatched = 0;
    int         ack_count  = 0;
    logic [7:0] exp_q[$];
    vec_t       vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every acknowledged read pops one expected word.
    initial begin
        logic prev_ack;
        logic [7:0] exp_word;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rd_ack === 1'b1) begin
                ack_count++;
                check("ack_single_cycle", prev_ack, 0);
                check("ack_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_word = exp_q.pop_front();
                    check("rd_data", bus.rd_data, exp_word);
                end
            end
            prev_ack = bus.rd_ack;
        end
    end

    // Read from idle: ack must appear one edge after rd_req, then fall.
    task automatic do_read(input logic addr, input logic [7:0] exp, input string name);
        int lat;
        bit got;
        bus.rd_addr = addr;
        bus.rd_req  = 1'b1;
        exp_q.push_back(exp);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.rd_ack === 1'b1) got = 1'b1;
        end
        check({name, "_ack_seen"}, got, 1);
        if (got) check({name, "_latency"}, lat, 1);
        else void'(exp_q.pop_back());
        bus.rd_req = 1'b0;
        @(negedge clk);
        check({name, "_ack_fall"}, bus.rd_ack, 0);
        @(negedge clk);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        bit got;
        int wait_n;

        rst         = 1'b1;
        sw          = 8'h00;
        btn         = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ack", bus.rd_ack, 0);
        check("reset_data", bus.rd_data, 8'h00);
        rst = 1'b0;

        vecs.push_back('{sw: 8'h00, btn: 1'b0, addr: 1'b0, exp: 8'h00});
        vecs.push_back('{sw: 8'hA5, btn: 1'b0, addr: 1'b0, exp: 8'hA5});
        vecs.push_back('{sw: 8'h3C, btn: 1'b0, addr: 1'b0, exp: 8'h3C});
        vecs.push_back('{sw: 8'hFF, btn: 1'b0, addr: 1'b0, exp: 8'hFF});
        vecs.push_back('{sw: 8'h01, btn: 1'b0, addr: 1'b0, exp: 8'h01});
        vecs.push_back('{sw: 8'h80, btn: 1'b0, addr: 1'b0, exp: 8'h80});
        vecs.push_back('{sw: 8'h80, btn: 1'b0, addr: 1'b1, exp: 8'h00});

        foreach (vecs[i]) begin
            sw  = vecs[i].sw;
            btn = vecs[i].btn;
            repeat (8) @(negedge clk);
            do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Glitch shorter than the debounce window must not move the level.
        sw = 8'hA5;
        repeat (8) @(negedge clk);
        do_read(1'b0, 8'hA5, "sw_a5");
        sw = 8'hFF;
        repeat (3) @(negedge clk);
        sw = 8'hA5;
        repeat (8) @(negedge clk);
        do_read(1'b0, 8'hA5, "sw_glitch");

        // Press latch: set by a press, cleared by the status read.
        btn = 1'b1;
        repeat (10) @(negedge clk);
        btn = 1'b0;
        repeat (8) @(negedge clk);
        do_read(1'b1, 8'h02, "pend_set");
        do_read(1'b1, 8'h00, "pend_cleared");
        btn = 1'b1;
        repeat (8) @(negedge clk);
        do_read(1'b1, 8'h03, "held_new_press");
        do_read(1'b1, 8'h01, "held_no_pend");

        // Capture lands exactly in the debounced rising-edge cycle.
        btn = 1'b0;
        repeat (8) @(negedge clk);
        do_read(1'b1, 8'h00, "released");
        btn = 1'b1;
        repeat (6) @(negedge clk);
        do_read(1'b1, 8'h01, "edge_collide");
        do_read(1'b1, 8'h03, "edge_set_wins");
        btn = 1'b0;

        // Held request yields a single ack; a one-cycle drop re-arms it.
        repeat (8) @(negedge clk);
        a0 = ack_count;
        bus.rd_addr = 1'b0;
        bus.rd_req  = 1'b1;
        exp_q.push_back(8'hA5);
        repeat (20) @(negedge clk);
        check("held_req_acks", ack_count - a0, 1);
        bus.rd_req = 1'b0;
        @(negedge clk);
        exp_q.push_back(8'hA5);
        bus.rd_req = 1'b1;
        got    = 1'b0;
        wait_n = 0;
        while (!got && wait_n < 3) begin
            @(negedge clk);
            wait_n++;
            if (bus.rd_ack === 1'b1) got = 1'b1;
        end
        check("rereq_ack_in_3", got, 1);
        if (!got) void'(exp_q.pop_back());
        bus.rd_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while in ACK with rd_req still high.
        bus.rd_addr = 1'b0;
        bus.rd_req  = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        check("pre_reset_ack", bus.rd_ack, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_ack", bus.rd_ack, 0);
        check("mid_reset_data", bus.rd_data, 8'h00);
        exp_q.push_back(8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ack", bus.rd_ack, 1);
        bus.rd_req = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_ack_fall", bus.rd_ack, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
